// File: rtl/bridge_pkg.sv
// Shared constants and helpers for the UART bridge tx/rx paths.
package bridge_pkg;
  localparam logic [7:0] PREAMBLE = 8'h4D;
  localparam logic [7:0] CR       = 8'h0D;
  localparam logic [7:0] LF       = 8'h0A;

  typedef enum logic {IDLE, SEND} tx_state_e;

  // 0-9 -> '0'-'9', 10-15 -> 'A'-'F'
  function automatic logic [7:0] to_ascii_hex(input logic [3:0] nib);
    return (nib < 4'd10) ? (8'h30 + {4'h0, nib}) : (8'h37 + {4'h0, nib});
  endfunction
endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy count; a push while full is only taken
// when a pop frees a slot on the same edge.
module sync_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic                     drop,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic             push_ok, pop_ok;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);
  assign drop    = push && !push_ok;
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(push_ok) - CW'(pop_ok);
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= wdata;
  end
endmodule

// File: rtl/bridge_tx_buffered.sv
// Buffers bus read responses and serialises each as 'M' + hex digits + [CR] LF
// toward the UART tx byte engine.
module bridge_tx_buffered
  import bridge_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int FIFO_DEPTH = 4,
  parameter bit APPEND_CR  = 1'b1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [DATA_WIDTH-1:0]         data_i,
  input  logic                          rw_i,
  input  logic                          valid_i,
  output logic [7:0]                    data_o,
  output logic                          start_o,
  input  logic                          done_i,
  output logic                          overflow_o,
  output logic [$clog2(FIFO_DEPTH):0]   count_o
);
  localparam int N  = DATA_WIDTH / 4;
  localparam int L  = 1 + N + (APPEND_CR ? 2 : 1);
  localparam int IW = $clog2(L);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  tx_state_e             state, state_n;
  logic [IW-1:0]         idx;
  logic [DATA_WIDTH-1:0] head;
  logic                  push, pop, last, drop;
  logic                  full, empty;

  assign push    = valid_i && !rw_i;
  assign last    = (idx == IW'(L - 1));
  assign pop     = (state == SEND) && done_i && last;
  assign start_o = (state == SEND);

  sync_fifo #(.WIDTH(DATA_WIDTH), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .wdata (data_i),
    .rdata (head),
    .full  (full),
    .empty (empty),
    .drop  (drop),
    .count (count_o)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      idx        <= '0;
      overflow_o <= 1'b0;
    end else begin
      state <= state_n;
      if (state == SEND && done_i) idx <= last ? '0 : idx + 1'b1;
      if (drop) overflow_o <= 1'b1;
    end
  end

  // Back-to-back frames: stay in SEND if anything remains after this pop.
  always_comb begin
    state_n = state;
    case (state)
      IDLE: if (!empty) state_n = SEND;
      SEND: if (pop && !(count_o > CW'(1) || push)) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    int                    k;
    logic [DATA_WIDTH-1:0] sh;
    k      = int'(idx);
    sh     = '0;
    data_o = PREAMBLE;
    if (k == 0) begin
      data_o = PREAMBLE;
    end else if (k <= N) begin
      sh     = head >> (4 * (N - k));
      data_o = to_ascii_hex(sh[3:0]);
    end else if (APPEND_CR && k == N + 1) begin
      data_o = CR;
    end else begin
      data_o = LF;
    end
  end
endmodule

// File: tb/tb_bridge_tx_buffered.sv
// Scoreboard bench: expected frame bytes queued when reads are driven, popped
// as a UART model accepts each offered byte.
module tb_bridge_tx_buffered;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] data_i = '0;
  logic        rw_i = 1'b0, valid_i = 1'b0, done_i = 1'b0;
  logic [7:0]  data_o;
  logic        start_o, overflow_o;
  logic [2:0]  count_o;

  logic [31:0] data2 = '0;
  logic        valid2 = 1'b0, done2 = 1'b0, rw2 = 1'b0;
  logic [7:0]  data_o2;
  logic        start2, ovf2;
  logic [2:0]  count2;

  int n_cmp = 0, n_err = 0;
  logic [7:0] exp_q[$];
  string hx = "0123456789ABCDEF";

  always #5 clk = ~clk;

  bridge_tx_buffered #(.DATA_WIDTH(16), .FIFO_DEPTH(4), .APPEND_CR(1'b1)) u_dut (
    .clk(clk), .rst(rst), .data_i(data_i), .rw_i(rw_i), .valid_i(valid_i),
    .data_o(data_o), .start_o(start_o), .done_i(done_i),
    .overflow_o(overflow_o), .count_o(count_o));

  bridge_tx_buffered #(.DATA_WIDTH(32), .FIFO_DEPTH(4), .APPEND_CR(1'b0)) u_dut32 (
    .clk(clk), .rst(rst), .data_i(data2), .rw_i(rw2), .valid_i(valid2),
    .data_o(data_o2), .start_o(start2), .done_i(done2),
    .overflow_o(ovf2), .count_o(count2));

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic exp_frame(input logic [31:0] w, input int nd, input bit cr);
    exp_q.push_back(8'h4D);
    for (int d = nd - 1; d >= 0; d--) exp_q.push_back(hx[(w >> (4 * d)) & 32'hF]);
    if (cr) exp_q.push_back(8'h0D);
    exp_q.push_back(8'h0A);
  endtask

  task automatic read16(input logic [15:0] w);
    data_i = w; valid_i = 1'b1; rw_i = 1'b0;
    step();
    valid_i = 1'b0;
  endtask

  // UART model: waits for an offered byte, holds dly cycles, returns it and pulses done_i.
  task automatic uart_byte(input int dly, output logic [7:0] b, output bit ok);
    int t = 0;
    while (!start_o && t < 50) begin step(); t++; end
    ok = start_o;
    b  = 8'hxx;
    if (!ok) return;
    repeat (dly) step();
    b = data_o;
    done_i = 1'b1;
    step();
    done_i = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; step(); step();
    n_cmp += 4;
    if (start_o !== 1'b0)    begin n_err++; $display("FAIL reset_start got %b want 0", start_o); end
    if (count_o !== 3'd0)    begin n_err++; $display("FAIL reset_count got %0d want 0", count_o); end
    if (overflow_o !== 1'b0) begin n_err++; $display("FAIL reset_ovf got %b want 0", overflow_o); end
    if (data_o !== 8'h4D)    begin n_err++; $display("FAIL reset_data got %h want 4d", data_o); end
    rst = 1'b0; step();
  endtask

  task automatic test_single();
    logic [7:0] b, e; bit ok;
    exp_frame(32'h1A2F, 4, 1'b1);
    read16(16'h1A2F);
    n_cmp += 3;
    if (start_o !== 1'b0) begin n_err++; $display("FAIL single_lat0 got %b want 0", start_o); end
    if (count_o !== 3'd1) begin n_err++; $display("FAIL single_cnt1 got %0d want 1", count_o); end
    step();
    if (start_o !== 1'b1) begin n_err++; $display("FAIL single_lat1 got %b want 1", start_o); end
    for (int i = 0; i < 7; i++) begin
      uart_byte(6, b, ok);
      e = exp_q.pop_front();
      n_cmp++;
      if (!ok || b !== e) begin n_err++; $display("FAIL single_byte%0d got %h want %h ok=%0d", i, b, e, ok); end
    end
    n_cmp += 2;
    if (start_o !== 1'b0) begin n_err++; $display("FAIL single_end_start got %b want 0", start_o); end
    if (count_o !== 3'd0) begin n_err++; $display("FAIL single_end_cnt got %0d want 0", count_o); end
  endtask

  task automatic test_nibbles();
    logic [7:0] b, e; bit ok;
    exp_frame(32'h09AF, 4, 1'b1);
    exp_frame(32'hF0F0, 4, 1'b1);
    read16(16'h09AF);
    read16(16'hF0F0);
    for (int i = 0; i < 14; i++) begin
      uart_byte(2, b, ok);
      e = exp_q.pop_front();
      n_cmp++;
      if (!ok || b !== e) begin n_err++; $display("FAIL nibble_byte%0d got %h want %h ok=%0d", i, b, e, ok); end
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] b, e; bit ok;
    logic [15:0] w [3] = '{16'h1234, 16'hABCD, 16'h5E6F};
    for (int i = 0; i < 3; i++) exp_frame({16'h0, w[i]}, 4, 1'b1);
    for (int i = 0; i < 3; i++) read16(w[i]);
    for (int i = 0; i < 21; i++) begin
      uart_byte(1, b, ok);
      e = exp_q.pop_front();
      n_cmp++;
      if (!ok || b !== e) begin n_err++; $display("FAIL b2b_byte%0d got %h want %h ok=%0d", i, b, e, ok); end
      if (i < 20) begin
        n_cmp++;
        if (start_o !== 1'b1) begin n_err++; $display("FAIL b2b_start_drop at byte %0d got %b want 1", i, start_o); end
      end
    end
    n_cmp++;
    if (overflow_o !== 1'b0) begin n_err++; $display("FAIL b2b_ovf got %b want 0", overflow_o); end
  endtask

  task automatic test_overflow();
    logic [7:0] b, e; bit ok;
    logic [15:0] w [6] = '{16'h1111, 16'h2222, 16'h3333, 16'h4444, 16'h5555, 16'h6666};
    for (int i = 0; i < 4; i++) exp_frame({16'h0, w[i]}, 4, 1'b1);
    exp_frame(32'h7ABC, 4, 1'b1);
    for (int i = 0; i < 6; i++) read16(w[i]);
    n_cmp += 2;
    if (overflow_o !== 1'b1) begin n_err++; $display("FAIL ovf_set got %b want 1", overflow_o); end
    if (count_o !== 3'd4)    begin n_err++; $display("FAIL ovf_cnt got %0d want 4", count_o); end
    for (int i = 0; i < 6; i++) begin
      uart_byte(2, b, ok);
      e = exp_q.pop_front();
      n_cmp++;
      if (!ok || b !== e) begin n_err++; $display("FAIL ovf_f0_byte%0d got %h want %h ok=%0d", i, b, e, ok); end
    end
    // last byte of frame 0 completes on the same edge as a push into the full FIFO
    repeat (2) step();
    e = exp_q.pop_front();
    n_cmp++;
    if (data_o !== e) begin n_err++; $display("FAIL ovf_f0_last got %h want %h", data_o, e); end
    done_i = 1'b1; valid_i = 1'b1; data_i = 16'h7ABC;
    step();
    done_i = 1'b0; valid_i = 1'b0;
    n_cmp += 2;
    if (count_o !== 3'd4)    begin n_err++; $display("FAIL ovf_pushpop_cnt got %0d want 4", count_o); end
    if (overflow_o !== 1'b1) begin n_err++; $display("FAIL ovf_sticky got %b want 1", overflow_o); end
    for (int i = 0; i < 28; i++) begin
      uart_byte(1, b, ok);
      e = exp_q.pop_front();
      n_cmp++;
      if (!ok || b !== e) begin n_err++; $display("FAIL ovf_rest_byte%0d got %h want %h ok=%0d", i, b, e, ok); end
    end
    n_cmp += 2;
    if (overflow_o !== 1'b1) begin n_err++; $display("FAIL ovf_hold got %b want 1", overflow_o); end
    if (start_o !== 1'b0)    begin n_err++; $display("FAIL ovf_idle got %b want 0", start_o); end
    rst = 1'b1; step(); rst = 1'b0;
    n_cmp++;
    if (overflow_o !== 1'b0) begin n_err++; $display("FAIL ovf_clear got %b want 0", overflow_o); end
  endtask

  task automatic test_reset_mid();
    logic [7:0] b, e; bit ok;
    read16(16'hAAAA); read16(16'hBBBB); read16(16'hCCCC);
    for (int i = 0; i < 3; i++) uart_byte(1, b, ok);
    rst = 1'b1; step(); rst = 1'b0;
    n_cmp += 4;
    if (start_o !== 1'b0)    begin n_err++; $display("FAIL rstmid_start got %b want 0", start_o); end
    if (count_o !== 3'd0)    begin n_err++; $display("FAIL rstmid_cnt got %0d want 0", count_o); end
    if (overflow_o !== 1'b0) begin n_err++; $display("FAIL rstmid_ovf got %b want 0", overflow_o); end
    if (data_o !== 8'h4D)    begin n_err++; $display("FAIL rstmid_data got %h want 4d", data_o); end
    data_i = 16'h5555; rw_i = 1'b1; valid_i = 1'b1;
    step(); step();
    valid_i = 1'b0; rw_i = 1'b0;
    n_cmp += 2;
    if (count_o !== 3'd0) begin n_err++; $display("FAIL rw_ignored_cnt got %0d want 0", count_o); end
    if (start_o !== 1'b0) begin n_err++; $display("FAIL rw_ignored_start got %b want 0", start_o); end
    exp_frame(32'h3C4D, 4, 1'b1);
    read16(16'h3C4D);
    for (int i = 0; i < 7; i++) begin
      uart_byte(3, b, ok);
      e = exp_q.pop_front();
      n_cmp++;
      if (!ok || b !== e) begin n_err++; $display("FAIL rstmid_fresh_byte%0d got %h want %h ok=%0d", i, b, e, ok); end
    end
  endtask

  task automatic test_params();
    logic [7:0] e; int t;
    exp_frame(32'hDEADBEEF, 8, 1'b0);
    data2 = 32'hDEADBEEF; valid2 = 1'b1; step(); valid2 = 1'b0;
    for (int i = 0; i < 10; i++) begin
      t = 0;
      while (!start2 && t < 50) begin step(); t++; end
      repeat (3) step();
      e = exp_q.pop_front();
      n_cmp++;
      if (!start2 || data_o2 !== e) begin n_err++; $display("FAIL w32_byte%0d got %h want %h start=%b", i, data_o2, e, start2); end
      done2 = 1'b1; step(); done2 = 1'b0;
    end
    n_cmp += 2;
    if (start2 !== 1'b0)   begin n_err++; $display("FAIL w32_end_start got %b want 0", start2); end
    if (count2 !== 3'd0)   begin n_err++; $display("FAIL w32_end_cnt got %0d want 0", count2); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_nibbles();
    test_back_to_back();
    test_overflow();
    test_reset_mid();
    test_params();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
